// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
// Entry layout carried from the ROM to decode.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP         = 32'h0000_0013;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of {pc, instr} entries between the ROM and decode.
// Flush empties the queue in one cycle; push and pop may coincide when full.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full
);

  fetch_entry_t  r_mem [DEPTH];
  fetch_entry_t  r_last;
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_last <= '0;
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
    end else if (flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr] <= din;
        r_wr        <= r_wr + PW'(1);
      end
      if (pop) begin
        r_last <= r_mem[r_rd];
        r_rd   <= r_rd + PW'(1);
      end
      if (push && !pop) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (pop && !push) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  // Empty queue keeps presenting the last consumed entry.
  assign head  = (r_cnt != '0) ? r_mem[r_rd] : r_last;
  assign count = r_cnt;
  assign full  = (r_cnt == CW'(DEPTH));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives the ROM address from the PC register, queues
// returned words, and honours redirects from execute with a flush.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        misalign
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   r_fetch_pc;
  logic          r_misalign;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_din;
  fetch_entry_t  w_head;

  assign out_valid = (w_count != '0);
  assign w_pop     = out_valid & out_ready;
  assign w_push    = fetch_en & ~redirect_valid & (~w_full | w_pop);
  assign w_din     = '{pc: r_fetch_pc, instr: instr_data};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .flush (redirect_valid),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .head  (w_head),
    .count (w_count),
    .full  (w_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= redirect_valid & (|redirect_addr[1:0]);
      if (redirect_valid) begin
        r_fetch_pc <= redirect_addr & ~32'h3;
      end else if (w_push) begin
        r_fetch_pc <= r_fetch_pc + INSTR_BYTES;
      end
    end
  end

  assign instr_addr = r_fetch_pc;
  assign out_pc     = w_head.pc;
  assign out_instr  = w_head.instr;
  assign misalign   = r_misalign;

endmodule
